// File: rtl/tdm_demux8_16.sv
// TDM receiver: demultiplexes an 8-slot framed word stream into 8 held channel registers
// with per-channel valid flags, frame completion, sync/timeout error pulses and a frame counter.
module tdm_demux8_16 #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic [8*WIDTH-1:0] ch_data,
    output logic [7:0]         ch_valid,
    output logic               frame_done,
    output logic               err_sync,
    output logic               err_timeout,
    output logic [7:0]         frame_count
);

    typedef enum logic [0:0] {StHunt, StRecv} state_e;

    // Idle count at which the next empty cycle completes the timeout.
    localparam logic [7:0] IdleLast = 8'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [2:0]              slot_q, slot_d;
    logic [7:0]              idle_q, idle_d;
    logic [7:0][WIDTH-1:0]   ch_data_q, ch_data_d;
    logic [7:0]              ch_valid_q, ch_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_sync_q, err_sync_d;
    logic                    err_timeout_q, err_timeout_d;
    logic [7:0]              frame_count_q, frame_count_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        idle_d        = idle_q;
        ch_data_d     = ch_data_q;
        ch_valid_d    = ch_valid_q;
        frame_done_d  = 1'b0;
        err_sync_d    = 1'b0;
        err_timeout_d = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StHunt: begin
                idle_d = 8'd0;
                if (in_valid && in_sof) begin
                    ch_data_d[0] = in_data;
                    ch_valid_d   = 8'h01;
                    slot_d       = 3'd1;
                    state_d      = StRecv;
                end
            end
            StRecv: begin
                if (in_valid) begin
                    idle_d = 8'd0;
                    if (in_sof) begin
                        // Early sof restarts the frame in place.
                        err_sync_d   = 1'b1;
                        ch_data_d[0] = in_data;
                        ch_valid_d   = 8'h01;
                        slot_d       = 3'd1;
                    end else begin
                        ch_data_d[slot_q]  = in_data;
                        ch_valid_d[slot_q] = 1'b1;
                        if (slot_q == 3'd7) begin
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 8'd1;
                            slot_d        = 3'd0;
                            state_d       = StHunt;
                        end else begin
                            slot_d = slot_q + 3'd1;
                        end
                    end
                end else if (idle_q == IdleLast) begin
                    // Abort: flags drop, channel data is kept.
                    err_timeout_d = 1'b1;
                    ch_valid_d    = 8'h00;
                    idle_d        = 8'd0;
                    slot_d        = 3'd0;
                    state_d       = StHunt;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StHunt;
            slot_q        <= 3'd0;
            idle_q        <= 8'd0;
            ch_data_q     <= '0;
            ch_valid_q    <= 8'h00;
            frame_done_q  <= 1'b0;
            err_sync_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            idle_q        <= idle_d;
            ch_data_q     <= ch_data_d;
            ch_valid_q    <= ch_valid_d;
            frame_done_q  <= frame_done_d;
            err_sync_q    <= err_sync_d;
            err_timeout_q <= err_timeout_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign frame_done  = frame_done_q;
    assign err_sync    = err_sync_q;
    assign err_timeout = err_timeout_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tdm_demux8_16.sv
// Self-checking bench for tdm_demux8_16: frame-level reference model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_tdm_demux8_16;

    localparam int W  = 16;
    localparam int TO = 16;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [8*W-1:0] ch_data;
    logic [7:0]     ch_valid;
    logic           frame_done;
    logic           err_sync;
    logic           err_timeout;
    logic [7:0]     frame_count;

    tdm_demux8_16 #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .frame_done  (frame_done),
        .err_sync    (err_sync),
        .err_timeout (err_timeout),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int fd_cnt = 0, es_cnt = 0, et_cnt = 0;

    // Reference model: channel contents, flags and frame progress as plain variables.
    logic [W-1:0] m_data [8];
    logic [7:0]   m_valid;
    bit           m_recv;
    int           m_slot, m_idle;
    logic         m_fd, m_es, m_et;
    logic [7:0]   m_fc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_data[i] = '0;
        m_valid = 8'h00;
        m_recv = 1'b0;
        m_slot = 0;
        m_idle = 0;
        m_fd = 1'b0;
        m_es = 1'b0;
        m_et = 1'b0;
        m_fc = 8'd0;
    endfunction

    function automatic void model_step(input logic v, input logic s, input logic [W-1:0] d);
        m_fd = 1'b0;
        m_es = 1'b0;
        m_et = 1'b0;
        if (v) begin
            m_idle = 0;
            if (s) begin
                m_es = m_recv;
                m_data[0] = d;
                m_valid = 8'h01;
                m_slot = 1;
                m_recv = 1'b1;
            end else if (m_recv) begin
                m_data[m_slot] = d;
                m_valid[m_slot] = 1'b1;
                if (m_slot == 7) begin
                    m_fd = 1'b1;
                    m_fc = m_fc + 8'd1;
                    m_recv = 1'b0;
                end else begin
                    m_slot++;
                end
            end
        end else if (m_recv) begin
            m_idle++;
            if (m_idle == TO) begin
                m_et = 1'b1;
                m_recv = 1'b0;
                m_valid = 8'h00;
                m_idle = 0;
            end
        end
    endfunction

    function automatic logic [127:0] m_packed();
        logic [127:0] p = '0;
        for (int i = 0; i < 8; i++) p[i*W +: W] = m_data[i];
        return p;
    endfunction

    // Compare process: DUT versus model every cycle, sampled mid-cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("ch_data", 128'(ch_data), m_packed());
            chk("ch_valid", 128'(ch_valid), 128'(m_valid));
            chk("frame_done", 128'(frame_done), 128'(m_fd));
            chk("err_sync", 128'(err_sync), 128'(m_es));
            chk("err_timeout", 128'(err_timeout), 128'(m_et));
            chk("frame_count", 128'(frame_count), 128'(m_fc));
            fd_cnt += int'(frame_done);
            es_cnt += int'(err_sync);
            et_cnt += int'(err_timeout);
        end
    end

    task automatic step(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        in_sof = s;
        in_data = d;
        @(posedge clock);
        #1;
        model_step(v, s, d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        model_reset();
        @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic frame(input logic [W-1:0] base);
        step(1'b1, 1'b1, base);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, base + W'(i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic chk_channels(input string name, input logic [W-1:0] base);
        logic [127:0] e = '0;
        for (int i = 0; i < 8; i++) e[i*W +: W] = base + W'(i);
        chk(name, 128'(ch_data), e);
    endtask

    int fd0, es0, et0;

    initial begin
        model_reset();
        #3;
        chk("reset_ch_data", 128'(ch_data), 128'd0);
        chk("reset_flags", 128'({ch_valid, frame_done, err_sync, err_timeout, frame_count}),
            128'd0);
        #4;
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Clean frame
        frame(16'h1000);
        idle(1);
        chk_channels("clean_data", 16'h1000);
        chk("clean_valid", 128'(ch_valid), 128'hFF);
        chk("clean_count", 128'(frame_count), 128'd1);
        chk("clean_done_pulses", 128'(fd_cnt), 128'd1);

        // Hunt discard
        do_reset();
        fd0 = fd_cnt; es0 = es_cnt; et0 = et_cnt;
        step(1'b1, 1'b0, 16'h0111);
        step(1'b1, 1'b0, 16'h0222);
        step(1'b1, 1'b0, 16'h0333);
        #2;
        chk("hunt_valid", 128'(ch_valid), 128'd0);
        chk("hunt_ch_data", 128'(ch_data), 128'd0);
        frame(16'h2000);
        idle(2);
        chk_channels("hunt_frame_data", 16'h2000);
        chk("hunt_errors", 128'((es_cnt - es0) + (et_cnt - et0)), 128'd0);
        chk("hunt_count", 128'(frame_count), 128'd1);

        // Early sof
        do_reset();
        es0 = es_cnt;
        step(1'b1, 1'b1, 16'hA000);
        for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i));
        #2;
        chk("early_partial_valid", 128'(ch_valid), 128'h1F);
        frame(16'hB000);
        idle(2);
        chk("early_sync_pulses", 128'(es_cnt - es0), 128'd1);
        chk_channels("early_data", 16'hB000);
        chk("early_count", 128'(frame_count), 128'd1);

        // Gaps: 5-cycle gaps, plus one TIMEOUT-1 gap that must not abort
        do_reset();
        et0 = et_cnt;
        step(1'b1, 1'b1, 16'h3000);
        for (int i = 1; i < 8; i++) begin
            idle((i == 4) ? TO - 1 : 5);
            step(1'b1, 1'b0, 16'h3000 + 16'(i));
        end
        idle(2);
        chk_channels("gap_data", 16'h3000);
        chk("gap_valid", 128'(ch_valid), 128'hFF);
        chk("gap_no_timeout", 128'(et_cnt - et0), 128'd0);

        // Timeout after slot 3
        step(1'b1, 1'b1, 16'h4000);
        for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 16'h4000 + 16'(i));
        idle(TO - 1);
        chk("to_not_yet", 128'(err_timeout), 128'd0);
        step(1'b0, 1'b0, '0);
        chk("to_pulse", 128'(err_timeout), 128'd1);
        for (int i = 4; i < 8; i++) step(1'b1, 1'b0, 16'h4000 + 16'(i));
        idle(1);
        chk("to_valid", 128'(ch_valid), 128'd0);
        chk("to_pulses", 128'(et_cnt - et0), 128'd1);
        chk("to_data_kept", 128'(ch_data[3*W +: W]), 128'h4003);
        chk("to_slot4_untouched", 128'(ch_data[4*W +: W]), 128'h3004);

        // 257 back-to-back frames
        do_reset();
        fd0 = fd_cnt;
        for (int f = 0; f < 257; f++) frame(16'(f * 8));
        idle(2);
        chk("wrap_count", 128'(frame_count), 128'd1);
        chk("wrap_pulses", 128'(fd_cnt - fd0), 128'd257);
        chk_channels("wrap_last_data", 16'(256 * 8));

        // Asynchronous reset mid-frame
        do_reset();
        frame(16'h5000);
        step(1'b1, 1'b1, 16'h6000);
        for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 16'h6000 + 16'(i));
        #1;
        chk("pre_reset_valid", 128'(ch_valid), 128'h1F);
        chk("pre_reset_count", 128'(frame_count), 128'd1);
        reset_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("async_ch_data", 128'(ch_data), 128'd0);
        chk("async_flags", 128'({ch_valid, frame_done, err_sync, err_timeout, frame_count}),
            128'd0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        frame(16'hC000);
        idle(1);
        chk_channels("post_reset_data", 16'hC000);
        chk("post_reset_valid", 128'(ch_valid), 128'hFF);
        chk("post_reset_count", 128'(frame_count), 128'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
